// File: rtl/tone_seq_pkg.sv
// Shared types, field widths and note tables for the tone sequencer.
// A note entry is {half_period, duration}; duration 0 terminates the melody.
package tone_seq_pkg;

    localparam int HALF_W = 8;
    localparam int DUR_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [HALF_W-1:0] half_period;
        logic [DUR_W-1:0]  duration;
    } note_t;

    function automatic note_t mk_note(input logic [HALF_W-1:0] half_period,
                                      input logic [DUR_W-1:0]  duration);
        note_t n;
        n.half_period = half_period;
        n.duration    = duration;
        return n;
    endfunction

    // Half periods are in 48 kHz samples: C5, D5, E5, F5, G5, A5 and back down.
    function automatic note_t melody_note(input logic [31:0] idx);
        note_t n;
        n = '0;
        case (idx)
            0:  n = mk_note(8'd46, 16'd12000);
            1:  n = mk_note(8'd41, 16'd12000);
            2:  n = mk_note(8'd36, 16'd12000);
            3:  n = mk_note(8'd34, 16'd12000);
            4:  n = mk_note(8'd31, 16'd24000);
            5:  n = mk_note(8'd0,  16'd6000);
            6:  n = mk_note(8'd27, 16'd12000);
            7:  n = mk_note(8'd31, 16'd12000);
            8:  n = mk_note(8'd34, 16'd12000);
            9:  n = mk_note(8'd36, 16'd12000);
            10: n = mk_note(8'd41, 16'd12000);
            11: n = mk_note(8'd46, 16'd24000);
            default: n = '0;
        endcase
        return n;
    endfunction

    function automatic note_t test_note(input logic [31:0] idx);
        note_t n;
        n = '0;
        case (idx)
            0:  n = mk_note(8'd4, 16'd16);
            1:  n = mk_note(8'd0, 16'd8);
            default: n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tone_sequencer_note_rom.sv
// Combinational note table lookup; entries past the end of a table read as terminators.
module note_rom
    import tone_seq_pkg::*;
#(
    parameter int IDX_W          = 4,
    parameter bit USE_TEST_TABLE = 1'b0
) (
    input  logic [IDX_W-1:0]  idx_i,
    output logic [HALF_W-1:0] half_period_o,
    output logic [DUR_W-1:0]  duration_o
);

    note_t entry;

    always_comb begin
        entry = USE_TEST_TABLE ? test_note(32'(idx_i)) : melody_note(32'(idx_i));
        half_period_o = entry.half_period;
        duration_o    = entry.duration;
    end

endmodule

// File: rtl/tone_sequencer.sv
// Melody controller feeding the codec output FIFO: square-wave notes with silent gaps.
// state | meaning: IDLE wait start | LOAD fetch entry | PLAY note samples | GAP silence | DONE end pulse
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int          NUM_NOTES      = 16,
    parameter logic [31:0] AMPLITUDE      = 32'd10000000,
    parameter logic [15:0] GAP_SAMPLES    = 16'd480,
    parameter bit          USE_TEST_TABLE = 1'b0
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop,
    input  logic                         audio_out_allowed,
    output logic                         write_audio_out,
    output logic [31:0]                  left_channel_audio_out,
    output logic [31:0]                  right_channel_audio_out,
    output logic                         busy,
    output logic [$clog2(NUM_NOTES)-1:0] note_index,
    output logic                         done
);

    localparam int              IDX_W    = $clog2(NUM_NOTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HALF_W-1:0]  half_q, half_d;
    logic [HALF_W-1:0]  phase_q, phase_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [15:0]        gap_q, gap_d;
    logic               pol_q, pol_d;
    logic               adv;
    logic [HALF_W-1:0]  rom_half;
    logic [DUR_W-1:0]   rom_dur;
    logic [31:0]        sample;

    note_rom #(
        .IDX_W          (IDX_W),
        .USE_TEST_TABLE (USE_TEST_TABLE)
    ) u_rom (
        .idx_i         (idx_q),
        .half_period_o (rom_half),
        .duration_o    (rom_dur)
    );

    // Gating with resetn keeps the FIFO from taking a sample in the reset cycle.
    assign write_audio_out = resetn && audio_out_allowed && !stop &&
                             (state_q == ST_PLAY || state_q == ST_GAP);

    always_comb begin
        sample = '0;
        if (state_q == ST_PLAY && half_q != '0) begin
            sample = pol_q ? AMPLITUDE : -AMPLITUDE;
        end
    end

    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE) && !stop;
    assign note_index = idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        half_d  = half_q;
        phase_d = phase_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        pol_d   = pol_q;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                half_d = rom_half;
                if (rom_dur == '0) begin
                    state_d = ST_DONE;
                end else begin
                    dur_d   = rom_dur;
                    phase_d = '0;
                    pol_d   = 1'b1;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (write_audio_out) begin
                    if (phase_q == half_q - 1'b1) begin
                        pol_d   = ~pol_q;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                    dur_d = dur_q - 1'b1;
                    if (dur_q == DUR_W'(1)) begin
                        if (GAP_SAMPLES != '0) begin
                            state_d = ST_GAP;
                            gap_d   = GAP_SAMPLES;
                        end else begin
                            adv = 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (write_audio_out) begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q == 16'd1) adv = 1'b1;
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = loop ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Running off the end of the table behaves like a terminator.
        if (adv) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_LOAD;
            end
        end
        if (stop && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            half_q  <= '0;
            phase_q <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            pol_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            pol_q   <= pol_d;
        end
    end

endmodule
